// File: rtl/mem_copy_engine.sv
// Block copy / constant fill engine that masters the data memory port while the CPU stalls.
// Copy alternates READ and WRITE around the memory's one-cycle synchronous read.
module mem_copy_engine #(
  parameter int unsigned ADDR_LIMIT = 4096,
  parameter int unsigned LEN_W      = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             fill_mode,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  input  logic [31:0]      fill_value,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             mem_write,
  output logic [31:0]      address,
  output logic [31:0]      write_data,
  input  logic [31:0]      read_data
);

  localparam int unsigned CW = 33;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [31:0]      r_src_ptr;
  logic [31:0]      r_dst_ptr;
  logic [31:0]      r_fill_value;
  logic [LEN_W-1:0] r_remaining;
  logic             r_fill_mode;
  logic             r_error;

  logic [CW-1:0]    w_src_end;
  logic [CW-1:0]    w_dst_end;
  logic             w_misaligned;
  logic             w_bad;
  logic             w_accept;

  // Range checks in 33 bits so a request can never wrap the 32-bit address space.
  assign w_src_end    = CW'(src_addr) + (CW'(len) << 2);
  assign w_dst_end    = CW'(dst_addr) + (CW'(len) << 2);
  assign w_misaligned = (dst_addr[1:0] != 2'b00) || (!fill_mode && (src_addr[1:0] != 2'b00));
  assign w_bad        = w_misaligned
                     || (w_dst_end > CW'(ADDR_LIMIT))
                     || (!fill_mode && (w_src_end > CW'(ADDR_LIMIT)));
  assign w_accept     = (r_state == IDLE) && start;
  assign error        = r_error;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_src_ptr    <= '0;
      r_dst_ptr    <= '0;
      r_fill_value <= '0;
      r_remaining  <= '0;
      r_fill_mode  <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_src_ptr    <= src_addr;
        r_dst_ptr    <= dst_addr;
        r_remaining  <= len;
        r_fill_mode  <= fill_mode;
        r_fill_value <= fill_value;
        r_error      <= w_bad;
      end else if (r_state == WRITE) begin
        r_src_ptr   <= r_src_ptr + 32'd4;
        r_dst_ptr   <= r_dst_ptr + 32'd4;
        r_remaining <= r_remaining - LEN_W'(1);
      end
    end
  end

  // Next state and memory-port decode; copy data flows straight from read_data.
  always_comb begin
    w_next     = r_state;
    busy       = 1'b0;
    done       = 1'b0;
    mem_write  = 1'b0;
    address    = '0;
    write_data = '0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (w_bad || (len == '0)) begin
            w_next = DONE;
          end else if (fill_mode) begin
            w_next = WRITE;
          end else begin
            w_next = READ;
          end
        end
      end
      READ: begin
        busy    = 1'b1;
        address = r_src_ptr;
        w_next  = WRITE;
      end
      WRITE: begin
        busy       = 1'b1;
        mem_write  = 1'b1;
        address    = r_dst_ptr;
        write_data = r_fill_mode ? r_fill_value : read_data;
        if (r_remaining == LEN_W'(1)) begin
          w_next = DONE;
        end else if (r_fill_mode) begin
          w_next = WRITE;
        end else begin
          w_next = READ;
        end
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule
